uart_tx_feeder: RTL and testbench

//  Transmit-side byte buffer and sequencer that sits directly upstream of the UART transmitter.

---
 rtl/uart_tx_feeder.sv | 128 ++++++++++++
 tb/tb_uart_tx_feeder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Transmit byte FIFO plus sequencer that hands one byte at a time to the UART
// transmitter and waits for its done edge before issuing the next character.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no character in flight; pop and start one when allowed
// WAIT  | character handed to transmitter, waiting for done rising edge
// GAP   | one settling cycle so the transmitter is idle with done low

module uart_tx_feeder #(
    parameter int DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [7:0]                   wdata_i,
    input  logic                         we_i,
    input  logic                         fifo_clr_i,
    input  logic                         tx_enable_i,
    input  logic [$clog2(DEPTH):0]       wm_thresh_i,
    input  logic                         tx_done_i,
    output logic                         tx_en_o,
    output logic [7:0]                   tx_byte_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       level_o,
    output logic                         ovf_o,
    output logic                         busy_o,
    output logic                         wm_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     level_q;
    logic            done_q;

    logic            full;
    logic            empty;
    logic            wr_ok;
    logic            pop;
    logic            done_rise;

    assign full      = (level_q == LEVEL_FULL);
    assign empty     = (level_q == '0);
    assign done_rise = tx_done_i & ~done_q;

    // A pop never frees a slot for a same-cycle write: fullness is judged
    // on the level before the pop, and a clear discards everything.
    assign wr_ok = we_i & ~full & ~fifo_clr_i;
    assign pop   = (state_q == ST_IDLE) & tx_enable_i & ~empty & ~fifo_clr_i;

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (fifo_clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            tx_en_o   <= 1'b0;
            tx_byte_o <= 8'h00;
            ovf_o     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= tx_done_i;
            tx_en_o <= pop;
            ovf_o   <= we_i & full & ~fifo_clr_i;
            if (pop) begin
                tx_byte_o <= mem[rd_ptr_q];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pop)       state_d = ST_WAIT;
            ST_WAIT: if (done_rise) state_d = ST_GAP;
            ST_GAP:                 state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    assign full_o  = full;
    assign empty_o = empty;
    assign level_o = level_q;
    assign busy_o  = (state_q != ST_IDLE) | ~empty;
    assign wm_o    = (level_q < wm_thresh_i);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a queue-based model of the feeder.

module tb_uart_tx_feeder;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic [7:0]  wdata;
    logic        we;
    logic        fifo_clr;
    logic        tx_enable;
    logic [4:0]  wm_thresh;
    logic        tx_done;
    logic        tx_en_o;
    logic [7:0]  tx_byte_o;
    logic        full_o;
    logic        empty_o;
    logic [4:0]  level_o;
    logic        ovf_o;
    logic        busy_o;
    logic        wm_o;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wdata_i     (wdata),
        .we_i        (we),
        .fifo_clr_i  (fifo_clr),
        .tx_enable_i (tx_enable),
        .wm_thresh_i (wm_thresh),
        .tx_done_i   (tx_done),
        .tx_en_o     (tx_en_o),
        .tx_byte_o   (tx_byte_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .level_o     (level_o),
        .ovf_o       (ovf_o),
        .busy_o      (busy_o),
        .wm_o        (wm_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: contents as a queue, one in-flight flag, and the first edge at
    // which a new start may be taken after a done rising edge.
    logic [7:0] mq [$];
    bit         m_inflight;
    int         m_idle_from;
    bit         m_prev_done;
    logic [7:0] m_byte;
    bit         m_en;
    bit         m_ovf;
    int         edge_n;
    bit         m_dr;
    bit         m_pop;
    bit         m_full;

    initial begin
        edge_n = 0;
        forever begin
            @(posedge clk);
            edge_n++;
            if (!rst_n) begin
                mq.delete();
                m_inflight  = 0;
                m_idle_from = 0;
                m_prev_done = 0;
                m_byte      = 8'h00;
                m_en        = 0;
                m_ovf       = 0;
            end else begin
                m_dr        = tx_done && !m_prev_done;
                m_prev_done = tx_done;
                m_full      = (mq.size() == DEPTH);
                m_pop       = !m_inflight && (edge_n >= m_idle_from) && tx_enable
                              && (mq.size() > 0) && !fifo_clr;
                m_ovf       = we && m_full && !fifo_clr;
                m_en        = m_pop;
                if (fifo_clr) begin
                    mq.delete();
                end else begin
                    if (m_pop) m_byte = mq.pop_front();
                    if (we && !m_full) mq.push_back(wdata);
                end
                if (m_inflight && m_dr) begin
                    m_inflight  = 0;
                    m_idle_from = edge_n + 2;
                end else if (m_pop) begin
                    m_inflight = 1;
                end
            end
            #1;
            check("tx_en_o",   tx_en_o,   m_en);
            check("tx_byte_o", tx_byte_o, m_byte);
            check("level_o",   level_o,   mq.size());
            check("empty_o",   empty_o,   mq.size() == 0);
            check("full_o",    full_o,    mq.size() == DEPTH);
            check("ovf_o",     ovf_o,     m_ovf);
            check("busy_o",    busy_o,    m_inflight || (edge_n < m_idle_from - 1) || (mq.size() != 0));
            check("wm_o",      wm_o,      mq.size() < int'(wm_thresh));
        end
    end

    // Transmitter stand-in: done goes high 2 cycles, a few cycles after each start.
    int         tx_cnt = 0;
    int         done_left = 0;
    logic [7:0] txlog [$];

    task automatic cyc();
        @(posedge clk);
        #2;
        if (tx_en_o) begin
            txlog.push_back(tx_byte_o);
            tx_cnt = $urandom_range(2, 6);
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) done_left = 2;
        end
        tx_done = (done_left > 0);
        if (done_left > 0) done_left--;
    endtask

    task automatic tx_reset();
        tx_cnt    = 0;
        done_left = 0;
        tx_done   = 1'b0;
    endtask

    task automatic write_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            we    = 1'b1;
            wdata = base + 8'(i);
            cyc();
        end
        we = 1'b0;
    endtask

    int wprob;

    initial begin
        rst_n     = 1'b0;
        wdata     = 8'h00;
        we        = 1'b0;
        fifo_clr  = 1'b0;
        tx_enable = 1'b0;
        wm_thresh = 5'd4;
        tx_done   = 1'b0;

        // Reset values, watermark follows threshold during reset
        cyc();
        check("rst_level", level_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_wm_nonzero", wm_o, 1);
        wm_thresh = 5'd0;
        #1;
        check("rst_wm_zero", wm_o, 0);
        wm_thresh = 5'd4;
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: single byte, start pulse two cycles after the write
        tx_enable = 1'b1;
        we = 1'b1;
        wdata = 8'hA5;
        cyc();
        we = 1'b0;
        check("s1_level1", level_o, 1);
        check("s1_noen", tx_en_o, 0);
        cyc();
        check("s1_en", tx_en_o, 1);
        check("s1_byte", tx_byte_o, 8'hA5);
        check("s1_level0", level_o, 0);
        check("s1_busy", busy_o, 1);
        cyc();
        check("s1_single", tx_en_o, 0);
        repeat (15) cyc();
        check("s1_idle", busy_o, 0);

        // 2: three back-to-back bytes go out in order
        txlog.delete();
        write_bytes(3, 8'h01);
        repeat (45) cyc();
        check("s2_count", txlog.size(), 3);
        if (txlog.size() == 3) begin
            check("s2_b0", txlog[0], 8'h01);
            check("s2_b1", txlog[1], 8'h02);
            check("s2_b2", txlog[2], 8'h03);
        end

        // 3: fill past full with transmission disabled
        tx_enable = 1'b0;
        for (int i = 0; i < 17; i++) begin
            we = 1'b1;
            wdata = 8'h10 + 8'(i);
            cyc();
            if (i == 15) begin
                check("s3_full", full_o, 1);
                check("s3_level16", level_o, 16);
            end
            if (i == 16) begin
                check("s3_ovf", ovf_o, 1);
                check("s3_level_kept", level_o, 16);
            end
        end
        we = 1'b0;
        cyc();
        check("s3_ovf_pulse", ovf_o, 0);
        txlog.delete();
        tx_enable = 1'b1;
        cyc();
        cyc();
        check("s3_first_out", txlog.size() > 0 ? txlog[0] : 8'hXX, 8'h10);
        repeat (200) cyc();
        check("s3_drained", txlog.size(), 16);

        // 4: clear with a same-cycle write while a character is in flight
        tx_enable = 1'b0;
        write_bytes(6, 8'h40);
        txlog.delete();
        tx_enable = 1'b1;
        cyc();
        check("s4_level5", level_o, 5);
        fifo_clr = 1'b1;
        we = 1'b1;
        wdata = 8'hEE;
        cyc();
        fifo_clr = 1'b0;
        we = 1'b0;
        check("s4_level0", level_o, 0);
        check("s4_empty", empty_o, 1);
        check("s4_no_ovf", ovf_o, 0);
        repeat (30) cyc();
        check("s4_one_char", txlog.size(), 1);
        check("s4_idle", busy_o, 0);

        // 5: watermark boundary, write+pop at level 4
        tx_enable = 1'b0;
        wm_thresh = 5'd4;
        write_bytes(3, 8'h60);
        check("s5_wm_l3", wm_o, 1);
        write_bytes(1, 8'h63);
        check("s5_wm_l4", wm_o, 0);
        check("s5_level4", level_o, 4);
        tx_enable = 1'b1;
        we = 1'b1;
        wdata = 8'h64;
        cyc();
        we = 1'b0;
        tx_enable = 1'b0;
        check("s5_wr_pop_level", level_o, 4);
        check("s5_wr_pop_en", tx_en_o, 1);
        check("s5_wr_pop_byte", tx_byte_o, 8'h60);
        repeat (20) cyc();

        // 6: asynchronous reset while waiting with two bytes queued
        fifo_clr = 1'b1;
        cyc();
        fifo_clr = 1'b0;
        write_bytes(3, 8'h70);
        tx_enable = 1'b1;
        cyc();
        tx_enable = 1'b0;
        check("s6_level2", level_o, 2);
        rst_n = 1'b0;
        #1;
        check("s6_level", level_o, 0);
        check("s6_empty", empty_o, 1);
        check("s6_full", full_o, 0);
        check("s6_en", tx_en_o, 0);
        check("s6_byte", tx_byte_o, 8'h00);
        check("s6_busy", busy_o, 0);
        check("s6_ovf", ovf_o, 0);
        tx_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Randomized traffic with varying write density
        for (int seg = 0; seg < 12; seg++) begin
            wprob = $urandom_range(0, 100);
            wm_thresh = 5'($urandom_range(0, 16));
            for (int c = 0; c < 250; c++) begin
                we        = ($urandom_range(0, 99) < wprob);
                wdata     = 8'($urandom);
                fifo_clr  = ($urandom_range(0, 199) == 0);
                tx_enable = ($urandom_range(0, 9) != 0);
                cyc();
            end
        end
        we = 1'b0;
        fifo_clr = 1'b0;
        tx_enable = 1'b1;
        repeat (300) cyc();
        check("end_idle", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
